// File: rtl/countdown_sprite_ctrl.sv
// 3-2-1 countdown overlay: steps a digit sprite once per FRAMES_PER_DIGIT frames
// and emits the opaque sprite pixels. Optional macro COUNTDOWN_BLINK_EN blanks the digit late in each interval.
module countdown_sprite_ctrl #(
  parameter int FRAMES_PER_DIGIT = 60,
  parameter int X0               = 304,
  parameter int Y0               = 228,
  parameter int KEY_COLOR        = 391
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       abort,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] sprite_px,
  output logic [1:0] digit_sel,
  output logic [4:0] sprite_row,
  output logic [4:0] sprite_col,
  output logic       pixel_valid,
  output logic [9:0] pixel_out,
  output logic       busy,
  output logic       done
);

  // Encoding doubles as the ROM select, so digit_sel comes straight off the state flops.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW1 = 2'd1,
    SHOW2 = 2'd2,
    SHOW3 = 2'd3
  } state_t;

  localparam logic [7:0] RELOAD = 8'(FRAMES_PER_DIGIT - 1);
  localparam logic [9:0] KEY    = 10'(KEY_COLOR);

  state_t     state;
  logic [7:0] cnt;
  logic       in_win;
  logic       show;
  logic       hit;

  assign digit_sel  = state;
  assign busy       = (state != IDLE);
  assign sprite_row = 5'(DrawY - 10'(Y0));
  assign sprite_col = 5'(DrawX - 10'(X0));

  assign in_win = (int'(DrawX) >= X0) && (int'(DrawX) <= X0 + 31) &&
                  (int'(DrawY) >= Y0) && (int'(DrawY) <= Y0 + 23);

`ifdef COUNTDOWN_BLINK_EN
  localparam logic [7:0] BLANK_AT = 8'(FRAMES_PER_DIGIT / 4);
  assign show = (cnt >= BLANK_AT);
`else
  assign show = 1'b1;
`endif

  assign hit = busy && in_win && (sprite_px != KEY) && show;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_out   <= '0;
    end else begin
      done        <= 1'b0;
      pixel_valid <= hit;
      pixel_out   <= hit ? sprite_px : '0;
      if (state == IDLE) begin
        // start takes priority over a same-cycle tick: the fresh load is not decremented.
        if (start) begin
          state <= SHOW3;
          cnt   <= RELOAD;
        end
      end else if (abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (frame_tick) begin
        if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end else begin
          case (state)
            SHOW3:   begin state <= SHOW2; cnt <= RELOAD; end
            SHOW2:   begin state <= SHOW1; cnt <= RELOAD; end
            default: begin state <= IDLE;  done <= 1'b1;  end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_sprite_ctrl.sv
// Directed plus randomized checks of countdown_sprite_ctrl against a tick-count
// reference model of the countdown and the sprite window.
module tb_countdown_sprite_ctrl;

  localparam int FPD = 2;
  localparam int X0  = 304;
  localparam int Y0  = 228;
  localparam int KEY = 391;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, abort = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, sprite_px = '0;
  logic [1:0] digit_sel;
  logic [4:0] sprite_row, sprite_col;
  logic       pixel_valid, busy, done;
  logic [9:0] pixel_out;

  countdown_sprite_ctrl #(.FRAMES_PER_DIGIT(FPD), .X0(X0), .Y0(Y0), .KEY_COLOR(KEY)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start), .abort(abort),
    .DrawX(DrawX), .DrawY(DrawY), .sprite_px(sprite_px),
    .digit_sel(digit_sel), .sprite_row(sprite_row), .sprite_col(sprite_col),
    .pixel_valid(pixel_valid), .pixel_out(pixel_out), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int nchk = 0;
  int nfail = 0;

  // Model: countdown is just "how many ticks since start"; digit and counter derive from it.
  bit running = 0;
  int ticks = 0;
  bit exp_done = 0;
  bit exp_pv = 0;
  int exp_po = 0;

  function automatic int m_digit();
    return running ? 3 - ticks / FPD : 0;
  endfunction

  function automatic int m_cnt();
    return running ? FPD - 1 - ticks % FPD : 0;
  endfunction

  function automatic bit m_inwin(int x, int y);
    return x >= X0 && x < X0 + 32 && y >= Y0 && y < Y0 + 24;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".digit"}, 32'(digit_sel), 32'(m_digit()));
    chk({tag, ".busy"}, 32'(busy), 32'(running));
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
    chk({tag, ".pv"}, 32'(pixel_valid), 32'(exp_pv));
    chk({tag, ".po"}, 32'(pixel_out), 32'(exp_po));
  endtask

  // One clock: drive at negedge, check combinational outputs, clock, update model, check registers.
  task automatic cycle(input string tag, input bit st, input bit ab, input bit tk,
                       input int x, input int y, input int px);
    bit hit;
    bit show;
    @(negedge Clk);
    start = st; abort = ab; frame_tick = tk;
    DrawX = 10'(x); DrawY = 10'(y); sprite_px = 10'(px);
    #1;
    chk({tag, ".digit_pre"}, 32'(digit_sel), 32'(m_digit()));
    if (m_inwin(x, y)) begin
      chk({tag, ".row"}, 32'(sprite_row), 32'(y - Y0));
      chk({tag, ".col"}, 32'(sprite_col), 32'(x - X0));
    end
`ifdef COUNTDOWN_BLINK_EN
    show = m_cnt() >= FPD / 4;
`else
    show = 1;
`endif
    hit = running && m_inwin(x, y) && px != KEY && show;
    @(posedge Clk);
    exp_pv = hit;
    exp_po = hit ? px : 0;
    exp_done = 0;
    if (!running) begin
      if (st) begin running = 1; ticks = 0; end
    end else if (ab) begin
      running = 0;
    end else if (tk) begin
      ticks++;
      if (ticks == 3 * FPD) begin running = 0; exp_done = 1; end
    end
    #1;
    check_regs(tag);
  endtask

  task automatic model_reset();
    running = 0; ticks = 0; exp_done = 0; exp_pv = 0; exp_po = 0;
  endtask

  initial begin
    // Reset state
    model_reset();
    #3;
    check_regs("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Full countdown with idle gaps between ticks
    cycle("start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle("gap", 0, 0, 0, 0, 0, 0);
      cycle("tick", 0, 0, 1, 0, 0, 0);
    end
    cycle("after_done", 0, 0, 0, 0, 0, 0);

    // Window corner, opaque and key colour, in SHOW3
    cycle("start2", 1, 0, 0, 0, 0, 0);
    cycle("corner_opaque", 0, 0, 0, 304, 228, 430);
    cycle("corner_key", 0, 0, 0, 304, 228, 391);
    cycle("tick_a", 0, 0, 1, 0, 0, 0);
    cycle("tick_b", 0, 0, 1, 0, 0, 0);
    // SHOW2: just outside vs far inside corner
    cycle("outside_x", 0, 0, 0, 336, 240, 430);
    cycle("outside_y", 0, 0, 0, 320, 252, 430);
    cycle("far_corner", 0, 0, 0, 335, 251, 123);
    // Abort beats tick in SHOW2
    cycle("abort_tick", 0, 1, 1, 0, 0, 0);
    cycle("abort_idle", 0, 1, 0, 0, 0, 0);
    cycle("idle_px", 0, 0, 0, 310, 230, 500);

    // Start ignored during SHOW1
    cycle("start3", 1, 0, 0, 0, 0, 0);
    repeat (4) cycle("to_show1", 0, 0, 1, 0, 0, 0);
    cycle("restart_ign", 1, 0, 0, 0, 0, 0);
    cycle("show1_tick", 0, 0, 1, 0, 0, 0);
    cycle("show1_end", 0, 0, 1, 0, 0, 0);

    // Start with tick in IDLE: tick must not consume the fresh load
    cycle("start_tick", 1, 0, 1, 0, 0, 0);
    cycle("t1", 0, 0, 1, 0, 0, 0);
    cycle("t2", 0, 0, 1, 310, 240, 77);
    // Asynchronous reset in SHOW2, mid-cycle
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_regs("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    cycle("post_rst_start", 1, 0, 0, 0, 0, 0);
    cycle("post_rst_t1", 0, 0, 1, 0, 0, 0);
    cycle("post_rst_t2", 0, 0, 1, 0, 0, 0);

    // Randomized traffic around the window
    for (int i = 0; i < 2000; i++) begin
      int x, y, px;
      bit st, ab, tk;
      x  = X0 - 2 + int'($urandom_range(0, 35));
      y  = Y0 - 2 + int'($urandom_range(0, 27));
      px = ($urandom_range(0, 3) == 0) ? KEY : int'($urandom_range(0, 1023));
      st = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 24) == 0);
      tk = ($urandom_range(0, 2) == 0);
      cycle("rand", st, ab, tk, x, y, px);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
